// File: rtl/main_onchip_memory2_0_master_if.sv
// Avalon-MM bus between the bulk-command master and the on-chip memory s1 port.
// Signal names follow the memory's s1 port so the slave side connects directly.
interface main_onchip_memory2_0_master_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned BE_W = DATA_W / 8;

    logic [ADDR_W-1:0] m_address;
    logic [BE_W-1:0]   m_byteenable;
    logic              m_chipselect;
    logic              m_write;
    logic [DATA_W-1:0] m_writedata;
    logic              m_clken;
    logic [DATA_W-1:0] m_readdata;

    modport master (
        output m_address,
        output m_byteenable,
        output m_chipselect,
        output m_write,
        output m_writedata,
        output m_clken,
        input  m_readdata
    );

    modport slave (
        input  m_address,
        input  m_byteenable,
        input  m_chipselect,
        input  m_write,
        input  m_writedata,
        input  m_clken,
        output m_readdata
    );
endinterface

// File: rtl/main_onchip_memory2_0_master.sv
// Bulk-command Avalon-MM master for the single-port on-chip memory:
// fill a word range with a pattern, copy a range, or verify a range.
// Optional feature macro: MEM_MASTER_VERIFY_EN builds in the verify command
// (mode 2) and the compare stage; without it mode 2 completes immediately
// like the reserved mode and mismatch/err_addr read as 0.
// The memory has a fixed 1-cycle read latency; pause drops m_clken and
// freezes the engine so the memory neither commits writes nor advances reads.
module main_onchip_memory2_0_master #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [ADDR_W-1:0]     src_addr,
    input  logic [ADDR_W-1:0]     dst_addr,
    input  logic [ADDR_W:0]       length,
    input  logic [DATA_W-1:0]     pattern,
    input  logic [(DATA_W/8)-1:0] be,
    input  logic                  pause,
    output logic                  busy,
    output logic                  done,
    output logic                  mismatch,
    output logic [ADDR_W-1:0]     err_addr,
    main_onchip_memory2_0_master_if.master m
);
    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned CNT_W = ADDR_W + 1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FILL      = 3'd1;
    localparam logic [2:0] S_COPY_RD   = 3'd2;
    localparam logic [2:0] S_COPY_WR   = 3'd3;
    localparam logic [2:0] S_VER_RD    = 3'd4;
    localparam logic [2:0] S_VER_DRAIN = 3'd5;
    localparam logic [2:0] S_FIN       = 3'd6;

    // FSM, word index and latched command
    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  idx_q,   idx_d;
    logic [CNT_W-1:0]  len_q,   len_d;
    logic [ADDR_W-1:0] src_q,   src_d;
    logic [ADDR_W-1:0] dst_q,   dst_d;
    logic [DATA_W-1:0] pat_q,   pat_d;
    logic [BE_W-1:0]   be_q,    be_d;

    // Registered status and bus outputs
    logic              busy_q,  busy_d;
    logic              done_q,  done_d;
    logic              cs_q,    cs_d;
    logic              wr_q,    wr_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [BE_W-1:0]   ben_q,   ben_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic hold;
    logic accept;
    logic last;

    // Pause only freezes states that own the bus; IDLE and FIN run regardless
    assign hold   = pause && (state_q != S_IDLE) && (state_q != S_FIN);
    assign accept = start && (state_q == S_IDLE);
    assign last   = (idx_q == (len_q - CNT_W'(1)));

    // Next-state, counter, command latch and next bus-output decode
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        src_d   = src_q;
        dst_d   = dst_q;
        pat_d   = pat_q;
        be_d    = be_q;

        if (!hold) begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        idx_d = '0;
                        len_d = length;
                        src_d = src_addr;
                        dst_d = dst_addr;
                        pat_d = pattern;
                        be_d  = be;
                        if (length == '0) begin
                            state_d = S_FIN;
                        end else begin
                            case (mode)
                                2'd0:    state_d = S_FILL;
                                2'd1:    state_d = S_COPY_RD;
`ifdef MEM_MASTER_VERIFY_EN
                                2'd2:    state_d = S_VER_RD;
`endif
                                default: state_d = S_FIN;
                            endcase
                        end
                    end
                end
                S_FILL: begin
                    if (last) begin
                        state_d = S_FIN;
                    end else begin
                        idx_d = idx_q + CNT_W'(1);
                    end
                end
                S_COPY_RD: begin
                    state_d = S_COPY_WR;
                end
                S_COPY_WR: begin
                    if (last) begin
                        state_d = S_FIN;
                    end else begin
                        idx_d   = idx_q + CNT_W'(1);
                        state_d = S_COPY_RD;
                    end
                end
                S_VER_RD: begin
                    if (last) begin
                        state_d = S_VER_DRAIN;
                    end else begin
                        idx_d = idx_q + CNT_W'(1);
                    end
                end
                S_VER_DRAIN: begin
                    state_d = S_FIN;
                end
                S_FIN: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // Bus outputs are registered, so decode them from the state being entered
        cs_d    = 1'b0;
        wr_d    = 1'b0;
        addr_d  = '0;
        ben_d   = '1;
        wdata_d = '0;
        case (state_d)
            S_FILL: begin
                cs_d    = 1'b1;
                wr_d    = 1'b1;
                addr_d  = dst_d + ADDR_W'(idx_d);
                ben_d   = be_d;
                wdata_d = pat_d;
            end
            S_COPY_RD: begin
                cs_d   = 1'b1;
                addr_d = src_d + ADDR_W'(idx_d);
            end
            S_COPY_WR: begin
                cs_d   = 1'b1;
                wr_d   = 1'b1;
                addr_d = dst_d + ADDR_W'(idx_d);
                ben_d  = be_d;
            end
            S_VER_RD: begin
                cs_d   = 1'b1;
                addr_d = dst_d + ADDR_W'(idx_d);
            end
            default: begin
                cs_d = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_FIN);
    end

    // State, command and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            pat_q   <= '0;
            be_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cs_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            ben_q   <= '1;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            pat_q   <= pat_d;
            be_q    <= be_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cs_q    <= cs_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            ben_q   <= ben_d;
            wdata_q <= wdata_d;
        end
    end

`ifdef MEM_MASTER_VERIFY_EN
    // Compare stage: checks the word read in the previous unpaused cycle
    logic              cmp_valid_q, cmp_valid_d;
    logic [ADDR_W-1:0] cmp_addr_q,  cmp_addr_d;
    logic              mism_q,      mism_d;
    logic [ADDR_W-1:0] err_q,       err_d;

    // Pipeline the read address and capture only the first failing word
    always_comb begin
        cmp_valid_d = cmp_valid_q;
        cmp_addr_d  = cmp_addr_q;
        mism_d      = mism_q;
        err_d       = err_q;
        if (accept) begin
            cmp_valid_d = 1'b0;
            mism_d      = 1'b0;
            err_d       = '0;
        end else if (!hold) begin
            cmp_valid_d = (state_q == S_VER_RD);
            cmp_addr_d  = addr_q;
            if (cmp_valid_q && (m.m_readdata != pat_q) && !mism_q) begin
                mism_d = 1'b1;
                err_d  = cmp_addr_q;
            end
        end
    end

    // Compare-stage registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmp_valid_q <= 1'b0;
            cmp_addr_q  <= '0;
            mism_q      <= 1'b0;
            err_q       <= '0;
        end else begin
            cmp_valid_q <= cmp_valid_d;
            cmp_addr_q  <= cmp_addr_d;
            mism_q      <= mism_d;
            err_q       <= err_d;
        end
    end

    assign mismatch = mism_q;
    assign err_addr = err_q;
`else
    assign mismatch = 1'b0;
    assign err_addr = '0;
`endif

    assign busy = busy_q;
    assign done = done_q;

    assign m.m_address    = addr_q;
    assign m.m_byteenable = ben_q;
    assign m.m_chipselect = cs_q;
    assign m.m_write      = wr_q;
    assign m.m_clken      = ~hold;
    // Copy write data arrives from the memory during the write cycle itself
    assign m.m_writedata  = (state_q == S_COPY_WR) ? m.m_readdata : wdata_q;

endmodule
